// File: rtl/store_unit.sv
// store_unit: write-side store path between the execute stage and data memory.
// Takes a store (byte address, rs2 data, func3), moves the byte/halfword onto the
// right lanes of a 32-bit word, builds byte strobes and issues one word-aligned
// valid/ready write. Reports completion (done) or a misalignment fault (misalign).
//
// Optional feature macro: STORE_MISALIGN_SPLIT_EN
//   defined   -> misaligned sh/sw are split into two word writes (W, then W+4);
//                misalign is tied low.
//   undefined -> misaligned sh/sw fault with a misalign pulse and no memory access.
//
// Ports:
//   clk, rst                 core clock; synchronous active-high reset
//   in_valid / in_ready      store request handshake (in_ready high only in IDLE)
//   in_addr, in_data, in_func3  byte address, rs2 data, 000 sb / 001 sh / else sw
//   mem_valid / mem_ready    data memory write handshake
//   mem_addr, mem_wdata, mem_wstrb  word-aligned address, lane data, byte enables
//   done                     one-cycle pulse when the store is fully committed
//   misalign                 one-cycle pulse when the store is rejected
module store_unit #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_data,
   input  logic [2:0]        in_func3,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   output logic              done,
   output logic              misalign
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

`ifdef STORE_MISALIGN_SPLIT_EN
   typedef enum logic [1:0] {IDLE, ISSUE, ISSUE2} state_t;
`else
   typedef enum logic [1:0] {IDLE, ISSUE} state_t;
`endif

   state_t state_q, state_d;

   logic              in_ready_d;
   logic              mem_valid_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic [STRB_W-1:0] mem_wstrb_d;
   logic              done_d;
   logic              misalign_d;

   // Lane placement of the incoming request
   logic [1:0]        k;
   logic [ADDR_W-1:0] word_addr;
   logic [DATA_W-1:0] lane_wdata;
   logic [STRB_W-1:0] lane_wstrb;
   logic              lane_misal;

   always_comb begin
      k          = in_addr[1:0];
      word_addr  = {in_addr[ADDR_W-1:2], 2'b00};
      lane_wdata = in_data;
      lane_wstrb = 4'b1111;
      lane_misal = 1'b0;
      case (in_func3)
         3'b000: begin
            lane_wdata = {4{in_data[7:0]}};
            lane_wstrb = 4'b0001 << k;
         end
         3'b001: begin
            lane_wdata = {2{in_data[15:0]}};
            lane_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
            lane_misal = in_addr[0];
         end
         default: begin
            lane_wdata = in_data;
            lane_wstrb = 4'b1111;
            lane_misal = (k != 2'b00);
         end
      endcase
   end

`ifdef STORE_MISALIGN_SPLIT_EN
   // Second-half word of a split store, captured at accept
   logic [2*DATA_W-1:0] split_data;
   logic [2*STRB_W-1:0] split_strb;
   logic [ADDR_W-1:0]   hi_addr_q, hi_addr_d;
   logic [DATA_W-1:0]   hi_wdata_q, hi_wdata_d;
   logic [STRB_W-1:0]   hi_wstrb_q, hi_wstrb_d;
   logic                hi_pend_q, hi_pend_d;

   // Data and strobes shifted across a 64-bit window: low half is word W, high half W+4
   always_comb begin
      split_data = (2*DATA_W)'(in_data) << {k, 3'b000};
      split_strb = ((in_func3 == 3'b001) ? 8'h03 : 8'h0F) << k;
   end
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      mem_valid_d = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_wstrb_d = mem_wstrb;
      done_d      = 1'b0;
      misalign_d  = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      hi_addr_d   = hi_addr_q;
      hi_wdata_d  = hi_wdata_q;
      hi_wstrb_d  = hi_wstrb_q;
      hi_pend_d   = hi_pend_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (!lane_misal) begin
                  state_d     = ISSUE;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = word_addr;
                  mem_wdata_d = lane_wdata;
                  mem_wstrb_d = lane_wstrb;
`ifdef STORE_MISALIGN_SPLIT_EN
                  hi_pend_d   = 1'b0;
`endif
               end else begin
`ifdef STORE_MISALIGN_SPLIT_EN
                  state_d     = ISSUE;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = word_addr;
                  mem_wdata_d = split_data[DATA_W-1:0];
                  mem_wstrb_d = split_strb[STRB_W-1:0];
                  hi_addr_d   = word_addr + ADDR_W'(4);
                  hi_wdata_d  = split_data[2*DATA_W-1:DATA_W];
                  hi_wstrb_d  = split_strb[2*STRB_W-1:STRB_W];
                  // sh at k=1 stays inside one word; no empty second write
                  hi_pend_d   = |split_strb[2*STRB_W-1:STRB_W];
`else
                  misalign_d  = 1'b1;
`endif
               end
            end
         end
         ISSUE: begin
            if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
               if (hi_pend_q) begin
                  state_d     = ISSUE2;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = hi_addr_q;
                  mem_wdata_d = hi_wdata_q;
                  mem_wstrb_d = hi_wstrb_q;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
`else
               state_d = IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               mem_valid_d = 1'b1;
            end
         end
`ifdef STORE_MISALIGN_SPLIT_EN
         ISSUE2: begin
            if (mem_ready) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               mem_valid_d = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b0;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         done      <= 1'b0;
         misalign  <= 1'b0;
      end else begin
         in_ready  <= in_ready_d;
         mem_valid <= mem_valid_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_wstrb <= mem_wstrb_d;
         done      <= done_d;
         misalign  <= misalign_d;
      end
   end

`ifdef STORE_MISALIGN_SPLIT_EN
   // Pending second-half registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_addr_q  <= '0;
         hi_wdata_q <= '0;
         hi_wstrb_q <= '0;
         hi_pend_q  <= 1'b0;
      end else begin
         hi_addr_q  <= hi_addr_d;
         hi_wdata_q <= hi_wdata_d;
         hi_wstrb_q <= hi_wstrb_d;
         hi_pend_q  <= hi_pend_d;
      end
   end
`endif

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed + random stores against a byte-level reference model.
// The model places each stored byte at address addr+i and groups bytes by word;
// it follows STORE_MISALIGN_SPLIT_EN the same way the design does.
module tb_store_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [2:0]  in_func3;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        done;
   logic        misalign;

   int errors = 0;
   int checks = 0;

   // Expected word writes for the current store
   logic [31:0] e_addr  [2];
   logic [31:0] e_wdata [2];
   logic [31:0] e_mask  [2];
   logic [3:0]  e_wstrb [2];
   int          e_n;
   bit          e_mis;

   store_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_func3(in_func3),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .done(done), .misalign(misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Byte-level reference: byte i of the store lands at address a+i
   task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      int          size;
      bit          mis;
      logic [31:0] ba;
      int          slot;
      int          lane;
      size = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
      mis  = (a % 32'(size)) != 32'd0;
      e_n  = 0;
      e_mis = 1'b0;
      for (int j = 0; j < 2; j++) begin
         e_addr[j] = '0; e_wdata[j] = '0; e_mask[j] = '0; e_wstrb[j] = '0;
      end
      if (!mis) begin
         e_n = 1;
         e_addr[0] = a & ~32'h3;
         for (int i = 0; i < size; i++)
            e_wstrb[0][int'((a + 32'(i)) % 32'd4)] = 1'b1;
         if (size == 1)      e_wdata[0] = 32'(d[7:0]) * 32'h0101_0101;
         else if (size == 2) e_wdata[0] = 32'(d[15:0]) * 32'h0001_0001;
         else                e_wdata[0] = d;
         e_mask[0] = 32'hFFFF_FFFF;
      end else begin
`ifdef STORE_MISALIGN_SPLIT_EN
         for (int i = 0; i < size; i++) begin
            ba   = a + 32'(i);
            slot = ((ba >> 2) != (a >> 2)) ? 1 : 0;
            lane = int'(ba % 32'd4);
            e_addr[slot]               = ba & ~32'h3;
            e_wstrb[slot][lane]        = 1'b1;
            e_wdata[slot][lane*8 +: 8] = d[i*8 +: 8];
            e_mask[slot][lane*8 +: 8]  = 8'hFF;
            if (slot + 1 > e_n) e_n = slot + 1;
         end
`else
         e_mis = 1'b1;
`endif
      end
   endtask

   task automatic check_write(input int w);
      chk("mem_valid", 32'(mem_valid), 32'd1);
      chk("mem_addr", mem_addr, e_addr[w]);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb[w]));
      chk("mem_wdata", mem_wdata & e_mask[w], e_wdata[w] & e_mask[w]);
      chk("no_done_in_issue", 32'(done), 32'd0);
      chk("no_misalign_in_issue", 32'(misalign), 32'd0);
   endtask

   // One store end to end; stall_in < 0 picks a random mem_ready delay per write
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                           input int stall_in);
      int n;
      int stall;
      model(a, d, f);
      n = 0;
      while (!in_ready && n < 10) begin
         tick();
         n++;
      end
      chk("accept_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_addr = a; in_data = d; in_func3 = f;
      tick();
      in_valid = 1'b0; in_addr = $urandom; in_data = $urandom; in_func3 = 3'($urandom);
      if (e_mis) begin
         chk("misalign_pulse", 32'(misalign), 32'd1);
         chk("misalign_no_valid", 32'(mem_valid), 32'd0);
         chk("misalign_no_done", 32'(done), 32'd0);
         chk("misalign_ready", 32'(in_ready), 32'd1);
         tick();
         chk("misalign_one_cycle", 32'(misalign), 32'd0);
         chk("misalign_no_valid2", 32'(mem_valid), 32'd0);
         return;
      end
      for (int w = 0; w < e_n; w++) begin
         stall = (stall_in < 0) ? int'($urandom_range(0, 3)) : stall_in;
         check_write(w);
         for (int s = 0; s < stall; s++) begin
            mem_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            tick();
            check_write(w);
         end
         mem_ready = 1'b1;
         tick();
         mem_ready = 1'b0;
         in_valid  = 1'b0;
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_valid_low", 32'(mem_valid), 32'd0);
      chk("done_ready", 32'(in_ready), 32'd1);
      chk("done_no_misalign", 32'(misalign), 32'd0);
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_func3 = '0; mem_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 32'(in_ready), 32'd1);

      do_store(32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0);
      do_store(32'h0000_2002, 32'h0000_BEEF, 3'b001, 3);
      do_store(32'h0000_3001, 32'h1122_3344, 3'b010, 0);
      do_store(32'hFFFF_FFFF, 32'h0000_A55A, 3'b001, 1);
      do_store(32'h0000_0101, 32'h0000_1234, 3'b001, 0);
      do_store(32'h0000_0040, 32'hCAFE_F00D, 3'b111, 2);

      // Reset in the middle of a stalled write
      model(32'h0000_0020, 32'h5555_AAAA, 3'b010);
      in_valid = 1'b1; in_addr = 32'h0000_0020; in_data = 32'h5555_AAAA; in_func3 = 3'b010;
      tick();
      in_valid = 1'b0;
      check_write(0);
      tick();
      chk("stalled_valid", 32'(mem_valid), 32'd1);
      rst = 1'b1;
      tick();
      chk("midrst_valid", 32'(mem_valid), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_misalign", 32'(misalign), 32'd0);
      chk("midrst_addr", mem_addr, 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      tick();
      chk("midrst_release_ready", 32'(in_ready), 32'd1);
      chk("midrst_no_done", 32'(done), 32'd0);
      do_store(32'h0000_0010, 32'h0BAD_F00D, 3'b010, 0);

      // Random stores across all func3 codes and address offsets
      for (int r = 0; r < 40; r++)
         do_store($urandom, $urandom, 3'($urandom_range(0, 7)), -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
